// File: rtl/centroid_accumulator_bank.sv
// Per-centroid coordinate sum / point count bank for the k-means update phase.
// Accumulates classified points, then drains {sum, count} per centroid in index order.
module centroid_accumulator_bank #(
  parameter int dataWidth        = 91,
  parameter int cordinate_width  = 13,
  parameter int accum_cord_width = 22,
  parameter int accum_width      = 154,
  parameter int centroid_num     = 8,
  parameter int count_width      = 10,
  parameter int idx_width        = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   point_valid,
  output logic                   point_ready,
  input  logic [dataWidth-1:0]   point,
  input  logic [idx_width-1:0]   centroid_idx,
  input  logic                   point_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [idx_width-1:0]   out_idx,
  output logic [accum_width-1:0] out_accum,
  output logic [count_width-1:0] out_count,
  output logic                   out_last,
  output logic                   pass_done,
  output logic                   overflow
);

  localparam int COORDS = dataWidth / cordinate_width;
  localparam logic [idx_width:0]   NUM_L    = (idx_width+1)'(centroid_num);
  localparam logic [idx_width-1:0] LAST_IDX = idx_width'(centroid_num - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [accum_width-1:0] sum_mem [centroid_num];
  logic [count_width-1:0] cnt_mem [centroid_num];
  logic                   pt_hs, out_hs, idx_ok, cnt_sat, is_last;
  logic [accum_width:0]   add_res;

  // Lane-wise add of a point into a packed sum; MSB of the result flags any lane carry-out.
  function automatic logic [accum_width:0] add_point(input logic [accum_width-1:0] acc,
                                                     input logic [dataWidth-1:0]   pt);
    logic [accum_width-1:0]  res;
    logic                    cy;
    logic [accum_cord_width:0] s;
    res = '0;
    cy  = 1'b0;
    for (int c = 0; c < COORDS; c++) begin
      s = {1'b0, acc[c*accum_cord_width +: accum_cord_width]}
        + {{(accum_cord_width+1-cordinate_width){1'b0}}, pt[c*cordinate_width +: cordinate_width]};
      res[c*accum_cord_width +: accum_cord_width] = s[accum_cord_width-1:0];
      cy = cy | s[accum_cord_width];
    end
    return {cy, res};
  endfunction

  assign point_ready = (state == ACCUM);
  assign out_valid   = (state == DRAIN);
  assign pt_hs       = point_valid & point_ready;
  assign out_hs      = out_valid & out_ready;
  assign idx_ok      = ({1'b0, centroid_idx} < NUM_L);
  assign is_last     = (out_idx == LAST_IDX);
  assign out_last    = out_valid & is_last;
  assign out_accum   = sum_mem[out_idx];
  assign out_count   = cnt_mem[out_idx];
  assign cnt_sat     = (cnt_mem[centroid_idx] == '1);
  assign add_res     = add_point(sum_mem[centroid_idx], point);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = ACCUM;
      ACCUM:   if (pt_hs && point_last) state_nxt = DRAIN;
      DRAIN:   if (out_hs && is_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_idx   <= '0;
      pass_done <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < centroid_num; i++) begin
        sum_mem[i] <= '0;
        cnt_mem[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      pass_done <= 1'b0;
      case (state)
        CLEAR: begin
          overflow <= 1'b0;
          out_idx  <= '0;
          for (int i = 0; i < centroid_num; i++) begin
            sum_mem[i] <= '0;
            cnt_mem[i] <= '0;
          end
        end
        ACCUM: begin
          if (pt_hs) begin
            // Out-of-range index: drop the point but still complete the handshake.
            if (idx_ok) begin
              sum_mem[centroid_idx] <= add_res[accum_width-1:0];
              if (!cnt_sat) cnt_mem[centroid_idx] <= cnt_mem[centroid_idx] + 1'b1;
              if (add_res[accum_width] || cnt_sat) overflow <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (is_last) begin
              out_idx   <= '0;
              pass_done <= 1'b1;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_accumulator_bank.sv
// Scoreboard bench for centroid_accumulator_bank: stimulus queues expected drain
// entries, a negedge monitor pops and compares on each drain handshake.
module tb_centroid_accumulator_bank;

  logic         clk = 1'b0;
  logic         rst_n, start, start6, point_valid, point_last, out_ready;
  logic [90:0]  point;
  logic [2:0]   centroid_idx;
  logic         point_ready, out_valid, out_last, pass_done, overflow;
  logic [2:0]   out_idx;
  logic [153:0] out_accum;
  logic [9:0]   out_count;
  logic         point_ready6, out_valid6, out_last6, pass_done6, overflow6;
  logic         out_ready6;
  logic [2:0]   out_idx6;
  logic [153:0] out_accum6;
  logic [9:0]   out_count6;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs6    = 0;
  int ready_drops = 0;
  bit stall_mode = 0;

  typedef struct {
    logic [2:0]   idx;
    logic [153:0] acc;
    logic [9:0]   cnt;
    logic         last;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  centroid_accumulator_bank dut (
    .clk(clk), .rst_n(rst_n), .start(start), .point_valid(point_valid),
    .point_ready(point_ready), .point(point), .centroid_idx(centroid_idx),
    .point_last(point_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_accum(out_accum), .out_count(out_count),
    .out_last(out_last), .pass_done(pass_done), .overflow(overflow)
  );

  centroid_accumulator_bank #(.centroid_num(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .point_valid(point_valid),
    .point_ready(point_ready6), .point(point), .centroid_idx(centroid_idx),
    .point_last(point_last), .out_valid(out_valid6), .out_ready(out_ready6),
    .out_idx(out_idx6), .out_accum(out_accum6), .out_count(out_count6),
    .out_last(out_last6), .pass_done(pass_done6), .overflow(overflow6)
  );

  assign out_ready6 = 1'b1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [90:0] rep(input logic [12:0] c);
    return {7{c}};
  endfunction

  function automatic logic [153:0] rep_sum(input logic [21:0] s);
    return {7{s}};
  endfunction

  // Eight drain entries, all zero except up to two hit entries (b may equal a).
  task automatic push_pass(input int a, input int sa, input int ca,
                           input int b, input int sb, input int cb);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.idx  = 3'(i);
      e.last = (i == 7);
      e.acc  = (i == a) ? rep_sum(22'(sa)) : (i == b) ? rep_sum(22'(sb)) : '0;
      e.cnt  = (i == a) ? 10'(ca) : (i == b) ? 10'(cb) : '0;
      exp_q.push_back(e);
    end
  endtask

  // Drain output stall driver.
  always @(posedge clk) begin
    #1 out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Main monitor: stability while stalled, scoreboard compare on handshake.
  logic         held_v = 1'b0;
  logic [2:0]   held_idx;
  logic [153:0] held_acc;
  logic [9:0]   held_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) begin
        chk("stall_idx", out_idx, held_idx);
        chk("stall_accum", out_accum, held_acc);
        chk("stall_count", out_count, held_cnt);
      end
      held_v   = out_valid && !out_ready;
      held_idx = out_idx;
      held_acc = out_accum;
      held_cnt = out_count;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain_unexpected: got idx %0d expected no entry", out_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("drain_idx", out_idx, e.idx);
          chk("drain_accum", out_accum, e.acc);
          chk("drain_count", out_count, e.cnt);
          chk("drain_last", out_last, e.last);
        end
      end
    end
  end

  // Second instance (6 centroids) only runs one pass: one hit at index 3 with coords 2.
  always @(negedge clk) begin
    if (rst_n && out_valid6) begin
      hs6++;
      chk("d6_count", out_count6, (out_idx6 == 3) ? 10'd1 : 10'd0);
      chk("d6_accum", out_accum6, (out_idx6 == 3) ? rep_sum(22'd2) : 154'd0);
      chk("d6_last", out_last6, (out_idx6 == 5));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 10 && !point_ready; i++) cyc();
    chk(name, point_ready, 1'b1);
  endtask

  task automatic send_burst(input int n, input logic [12:0] c, input logic [2:0] ia,
                            input logic [2:0] ib, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      point_valid  = 1'b1;
      point        = rep(c);
      centroid_idx = (i % 2 == 1) ? ib : ia;
      point_last   = last_at_end && (i == n - 1);
      if (!point_ready) ready_drops++;
      cyc();
    end
    point_valid = 1'b0;
    point_last  = 1'b0;
  endtask

  task automatic run_drain(input bit stall);
    bit seen = 0;
    stall_mode = stall;
    for (int i = 0; i < 300; i++) begin
      if (pass_done) begin
        seen = 1;
        break;
      end
      cyc();
    end
    chk("pass_done_seen", seen, 1'b1);
    chk("drain_handshakes", hs_cnt, 8);
    cyc();
    chk("pass_done_pulse", pass_done, 1'b0);
    chk("idle_out_valid", out_valid, 1'b0);
    stall_mode = 0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start6 = 1'b0; point_valid = 1'b0; point_last = 1'b0;
    point = '0; centroid_idx = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_point_ready", point_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_pass_done", pass_done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_out_idx", out_idx, 3'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_no_ready", point_ready, 1'b0);

    // T1: three unit points to idx 2
    hs_cnt = 0;
    push_pass(2, 3, 3, 2, 3, 3);
    pulse_start();
    wait_ready("t1_ready");
    send_burst(3, 13'd1, 3'd2, 3'd2, 1'b1);
    run_drain(1'b0);

    // T2: 100 back-to-back max points alternating idx 0/1, stalled drain
    hs_cnt = 0; ready_drops = 0;
    push_pass(0, 409550, 50, 1, 409550, 50);
    pulse_start();
    wait_ready("t2_ready");
    send_burst(100, 13'd8191, 3'd0, 3'd1, 1'b1);
    chk("t2_ready_drops", ready_drops, 0);
    chk("t2_overflow", overflow, 1'b0);
    run_drain(1'b1);

    // T3: 1024 max points to idx 5 -> count saturates, sums wrap
    hs_cnt = 0;
    push_pass(5, 4193280, 1023, 5, 4193280, 1023);
    pulse_start();
    wait_ready("t3_ready");
    send_burst(1024, 13'd8191, 3'd5, 3'd5, 1'b1);
    chk("t3_overflow", overflow, 1'b1);
    run_drain(1'b1);

    // T5: reset mid-accumulation, then a fresh single-point pass
    pulse_start();
    wait_ready("t5_ready");
    send_burst(5, 13'd3, 3'd0, 3'd1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_point_ready", point_ready, 1'b0);
    chk("t5_rst_out_valid", out_valid, 1'b0);
    chk("t5_rst_out_last", out_last, 1'b0);
    chk("t5_rst_pass_done", pass_done, 1'b0);
    chk("t5_rst_overflow", overflow, 1'b0);
    chk("t5_rst_out_idx", out_idx, 3'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    hs_cnt = 0;
    push_pass(7, 5, 1, 7, 5, 1);
    pulse_start();
    wait_ready("t5b_ready");
    send_burst(1, 13'd5, 3'd7, 3'd7, 1'b1);
    run_drain(1'b0);

    // T6: start ignored mid-pass; idx 7 is out of range for the 6-entry instance
    hs_cnt = 0; hs6 = 0;
    push_pass(3, 2, 1, 7, 1, 1);
    start = 1'b1; start6 = 1'b1;
    cyc();
    start = 1'b0; start6 = 1'b0;
    wait_ready("t6_ready");
    chk("t6_ready6", point_ready6, 1'b1);
    send_burst(1, 13'd1, 3'd7, 3'd7, 1'b0);
    pulse_start();
    chk("t6_still_accum", point_ready, 1'b1);
    send_burst(1, 13'd2, 3'd3, 3'd3, 1'b1);
    chk("t6_overflow_main", overflow, 1'b0);
    chk("t6_overflow6", overflow6, 1'b1);
    stall_mode = 1;
    cyc();
    pulse_start();
    run_drain(1'b1);
    chk("t6_d6_handshakes", hs6, 6);
    chk("t6_d6_idle", out_valid6, 1'b0);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
